// File: rtl/simt_branch_unit_if.sv
// Decoder/scheduler <-> branch unit bundle: decoded control flow plus the
// PC, active-lane mask, reconvergence depth and sticky fault flags.
interface simt_branch_unit_if #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int DATA_MEM_DATA_BITS    = 8,
    parameter int THREADS_PER_BLOCK     = 4,
    parameter int STACK_DEPTH           = 4
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic [3:0]                                core_state;
    logic                                      decoded_pc_mux;
    logic                                      decoded_jump;
    logic                                      decoded_ssy;
    logic                                      decoded_sync;
    logic [2:0]                                decoded_nzp;
    logic [DATA_MEM_DATA_BITS-1:0]             decoded_immediate;
    logic [THREADS_PER_BLOCK-1:0][2:0]         nzp;

    logic [PROGRAM_MEM_ADDR_BITS-1:0]          current_pc;
    logic [PROGRAM_MEM_ADDR_BITS-1:0]          next_pc;
    logic [THREADS_PER_BLOCK-1:0]              thread_mask;
    logic [DEPTH_W-1:0]                        stack_depth;
    logic                                      fault_overflow;
    logic                                      fault_underflow;
    logic                                      fault_divergence;

    modport master (
        output core_state, decoded_pc_mux, decoded_jump, decoded_ssy, decoded_sync,
               decoded_nzp, decoded_immediate, nzp,
        input  current_pc, next_pc, thread_mask, stack_depth,
               fault_overflow, fault_underflow, fault_divergence
    );

    modport slave (
        input  core_state, decoded_pc_mux, decoded_jump, decoded_ssy, decoded_sync,
               decoded_nzp, decoded_immediate, nzp,
        output current_pc, next_pc, thread_mask, stack_depth,
               fault_overflow, fault_underflow, fault_divergence
    );
endinterface

// File: rtl/simt_branch_unit.sv
// Per-block PC and active-lane mask with a reconvergence stack: divergent
// branches run the taken path first, then the fall-through path, and rejoin on SYNC.
module simt_branch_unit #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int DATA_MEM_DATA_BITS    = 8,
    parameter int THREADS_PER_BLOCK     = 4,
    parameter int STACK_DEPTH           = 4
) (
    input  logic                clk,
    input  logic                reset,
    simt_branch_unit_if.slave   bus
);
    localparam int PC_W    = PROGRAM_MEM_ADDR_BITS;
    localparam int IMM_W   = DATA_MEM_DATA_BITS;
    localparam int NT      = THREADS_PER_BLOCK;
    localparam int FIT_W   = (PC_W < IMM_W) ? PC_W : IMM_W;
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [3:0]         ST_EXECUTE = 4'b0110;
    localparam logic [3:0]         ST_UPDATE  = 4'b0111;
    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        OP_NONE,
        OP_PUSH,
        OP_SPLIT,
        OP_RESUME,
        OP_POP
    } stack_op_e;

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

    // Zero-extends or truncates the immediate to PC width.
    function automatic logic [PC_W-1:0] fit_imm(input logic [IMM_W-1:0] imm);
        logic [PC_W-1:0] r;
        r = '0;
        for (int i = 0; i < FIT_W; i++) r[i] = imm[i];
        return r;
    endfunction

    // Architectural state
    logic [PC_W-1:0]    current_pc;
    logic [NT-1:0]      thread_mask;
    logic [DEPTH_W-1:0] stack_depth;
    logic               fault_overflow;
    logic               fault_underflow;
    logic               fault_divergence;

    logic [PC_W-1:0]        reconv_pc    [STACK_DEPTH];
    logic [NT-1:0]          origin_mask  [STACK_DEPTH];
    logic [PC_W-1:0]        pending_pc   [STACK_DEPTH];
    logic [NT-1:0]          pending_mask [STACK_DEPTH];
    logic [STACK_DEPTH-1:0] pending_valid;

    // EXECUTE results awaiting UPDATE
    logic               vld_p1;
    stack_op_e          op_p1;
    logic [PC_W-1:0]    next_pc_p1;
    logic [NT-1:0]      next_mask_p1;
    logic [PC_W-1:0]    op_pc_p1;
    logic [NT-1:0]      op_mask_p1;

    logic               is_execute;
    logic               is_update;
    logic               stack_empty;
    logic               stack_full;
    logic               top_pending;
    logic [IDX_W-1:0]   top_idx;
    logic [IDX_W-1:0]   push_idx;
    logic [NT-1:0]      taken;
    logic [PC_W-1:0]    pc_plus1;
    logic [PC_W-1:0]    imm_pc;

    logic [PC_W-1:0]    exe_pc;
    logic [NT-1:0]      exe_mask;
    stack_op_e          exe_op;
    logic [PC_W-1:0]    exe_op_pc;
    logic [NT-1:0]      exe_op_mask;
    logic               set_overflow;
    logic               set_underflow;
    logic               set_divergence;

    assign is_execute  = (bus.core_state == ST_EXECUTE);
    assign is_update   = (bus.core_state == ST_UPDATE);
    assign stack_empty = (stack_depth == '0);
    assign stack_full  = (stack_depth == DEPTH_FULL);
    assign top_idx     = IDX_W'(stack_depth - DEPTH_W'(1));
    assign push_idx    = IDX_W'(stack_depth);
    assign top_pending = !stack_empty && pending_valid[top_idx];
    assign pc_plus1    = pc_inc(current_pc);
    assign imm_pc      = fit_imm(bus.decoded_immediate);

    always_comb begin
        taken = '0;
        for (int i = 0; i < NT; i++) begin
            taken[i] = thread_mask[i] & (|(bus.nzp[i] & bus.decoded_nzp));
        end
    end

    // ---- Stage p0: decode and resolve the control-flow outcome ----
    always_comb begin
        exe_pc         = pc_plus1;
        exe_mask       = thread_mask;
        exe_op         = OP_NONE;
        exe_op_pc      = imm_pc;
        exe_op_mask    = thread_mask;
        set_overflow   = 1'b0;
        set_underflow  = 1'b0;
        set_divergence = 1'b0;

        if (bus.decoded_pc_mux) begin
            if (taken == thread_mask) begin
                exe_pc = imm_pc;
            end else if (taken != '0) begin
                // Only one outstanding split per stack level: the fall-through
                // path is parked in the top entry until the matching SYNC.
                if (!stack_empty && !top_pending) begin
                    exe_op      = OP_SPLIT;
                    exe_op_pc   = pc_plus1;
                    exe_op_mask = thread_mask & ~taken;
                    exe_mask    = taken;
                    exe_pc      = imm_pc;
                end else begin
                    set_divergence = 1'b1;
                end
            end
        end else if (bus.decoded_jump) begin
            exe_pc = imm_pc;
        end else if (bus.decoded_ssy) begin
            if (stack_full) begin
                set_overflow = 1'b1;
            end else begin
                exe_op      = OP_PUSH;
                exe_op_pc   = imm_pc;
                exe_op_mask = thread_mask;
            end
        end else if (bus.decoded_sync) begin
            if (stack_empty) begin
                set_underflow = 1'b1;
            end else if (top_pending) begin
                exe_op   = OP_RESUME;
                exe_pc   = pending_pc[top_idx];
                exe_mask = pending_mask[top_idx];
            end else begin
                exe_op   = OP_POP;
                exe_pc   = pc_inc(reconv_pc[top_idx]);
                exe_mask = origin_mask[top_idx];
            end
        end
    end

    // ---- Stage p1: latch EXECUTE outcome, commit it on UPDATE ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1           <= 1'b0;
            op_p1            <= OP_NONE;
            next_pc_p1       <= '0;
            next_mask_p1     <= '1;
            current_pc       <= '0;
            thread_mask      <= '1;
            stack_depth      <= '0;
            pending_valid    <= '0;
            fault_overflow   <= 1'b0;
            fault_underflow  <= 1'b0;
            fault_divergence <= 1'b0;
        end else if (is_execute) begin
            vld_p1           <= 1'b1;
            op_p1            <= exe_op;
            next_pc_p1       <= exe_pc;
            next_mask_p1     <= exe_mask;
            fault_overflow   <= fault_overflow   | set_overflow;
            fault_underflow  <= fault_underflow  | set_underflow;
            fault_divergence <= fault_divergence | set_divergence;
        end else if (is_update && vld_p1) begin
            vld_p1      <= 1'b0;
            current_pc  <= next_pc_p1;
            thread_mask <= next_mask_p1;
            case (op_p1)
                OP_PUSH: begin
                    stack_depth             <= stack_depth + DEPTH_W'(1);
                    pending_valid[push_idx] <= 1'b0;
                end
                OP_SPLIT:  pending_valid[top_idx] <= 1'b1;
                OP_RESUME: pending_valid[top_idx] <= 1'b0;
                OP_POP: begin
                    stack_depth            <= stack_depth - DEPTH_W'(1);
                    pending_valid[top_idx] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (is_execute) begin
            op_pc_p1   <= exe_op_pc;
            op_mask_p1 <= exe_op_mask;
        end else if (is_update && vld_p1) begin
            case (op_p1)
                OP_PUSH: begin
                    reconv_pc[push_idx]   <= op_pc_p1;
                    origin_mask[push_idx] <= op_mask_p1;
                end
                OP_SPLIT: begin
                    pending_pc[top_idx]   <= op_pc_p1;
                    pending_mask[top_idx] <= op_mask_p1;
                end
                default: ;
            endcase
        end
    end

    assign bus.current_pc       = current_pc;
    assign bus.next_pc          = next_pc_p1;
    assign bus.thread_mask      = thread_mask;
    assign bus.stack_depth      = stack_depth;
    assign bus.fault_overflow   = fault_overflow;
    assign bus.fault_underflow  = fault_underflow;
    assign bus.fault_divergence = fault_divergence;
endmodule

// File: tb/tb_simt_branch_unit.sv
// Self-checking bench for simt_branch_unit: directed scenarios plus randomized
// instruction streams against an instruction-level model with a queue stack.
module tb_simt_branch_unit;
    localparam int PCW = 8;
    localparam int DW  = 8;
    localparam int NT  = 4;
    localparam int SD  = 2;
    localparam logic [3:0] ST_EXEC = 4'b0110;
    localparam logic [3:0] ST_UPD  = 4'b0111;
    localparam logic [3:0] ST_IDLE = 4'b0001;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    simt_branch_unit_if #(
        .PROGRAM_MEM_ADDR_BITS(PCW), .DATA_MEM_DATA_BITS(DW),
        .THREADS_PER_BLOCK(NT), .STACK_DEPTH(SD)
    ) bus ();

    simt_branch_unit #(
        .PROGRAM_MEM_ADDR_BITS(PCW), .DATA_MEM_DATA_BITS(DW),
        .THREADS_PER_BLOCK(NT), .STACK_DEPTH(SD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [7:0] reconv;
        logic [3:0] origin;
        logic [7:0] ppc;
        logic [3:0] pmask;
        logic       pv;
    } ent_t;

    ent_t       stk[$];
    logic [7:0] m_pc, m_npc;
    logic [3:0] m_mask;
    logic       m_fo, m_fu, m_fd;

    // Lane n flags occupy bits [3n+2:3n]; lanes 0 and 2 have Z, lane 1 N, lane 3 P.
    localparam logic [11:0] DIV_NZP = {3'b001, 3'b010, 3'b100, 3'b010};

    task automatic model_reset();
        stk.delete();
        m_pc = 8'h00; m_npc = 8'h00; m_mask = 4'hF;
        m_fo = 1'b0; m_fu = 1'b0; m_fd = 1'b0;
    endtask

    // Whole-instruction semantics: resolve, update stack, advance PC and mask at once.
    task automatic model_step(input logic pm, jmp, ssy, snc, input logic [2:0] dnzp,
                              input logic [7:0] imm, input logic [11:0] lnzp);
        logic [3:0] tk;
        logic [7:0] nxt;
        logic [3:0] nmask;
        ent_t e;
        for (int i = 0; i < NT; i++) tk[i] = m_mask[i] && ((lnzp[3*i +: 3] & dnzp) != 3'b000);
        nxt = m_pc + 8'd1;
        nmask = m_mask;
        if (pm) begin
            if (tk == m_mask) nxt = imm;
            else if (tk != 4'b0000) begin
                if (stk.size() == 0) m_fd = 1'b1;
                else begin
                    e = stk.pop_back();
                    if (e.pv) begin
                        m_fd = 1'b1;
                    end else begin
                        e.ppc = m_pc + 8'd1; e.pmask = m_mask & ~tk; e.pv = 1'b1;
                        nmask = tk; nxt = imm;
                    end
                    stk.push_back(e);
                end
            end
        end else if (jmp) begin
            nxt = imm;
        end else if (ssy) begin
            if (stk.size() == SD) m_fo = 1'b1;
            else begin
                e.reconv = imm; e.origin = m_mask; e.ppc = 8'h00; e.pmask = 4'h0; e.pv = 1'b0;
                stk.push_back(e);
            end
        end else if (snc) begin
            if (stk.size() == 0) m_fu = 1'b1;
            else begin
                e = stk.pop_back();
                if (e.pv) begin
                    nxt = e.ppc; nmask = e.pmask; e.pv = 1'b0;
                    stk.push_back(e);
                end else begin
                    nxt = e.reconv + 8'd1; nmask = e.origin;
                end
            end
        end
        m_npc = nxt; m_pc = nxt; m_mask = nmask;
    endtask

    task automatic drive_execute(input logic pm, jmp, ssy, snc, input logic [2:0] dnzp,
                                 input logic [7:0] imm, input logic [11:0] lnzp);
        bus.core_state = ST_EXEC;
        bus.decoded_pc_mux = pm; bus.decoded_jump = jmp;
        bus.decoded_ssy = ssy;   bus.decoded_sync = snc;
        bus.decoded_nzp = dnzp;  bus.decoded_immediate = imm;
        bus.nzp = lnzp;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Decode inputs are scrambled during UPDATE: only EXECUTE may sample them.
    task automatic drive_update();
        bus.core_state = ST_UPD;
        bus.decoded_pc_mux = 1'($urandom); bus.decoded_jump = 1'($urandom);
        bus.decoded_ssy = 1'($urandom);    bus.decoded_sync = 1'($urandom);
        bus.decoded_nzp = 3'($urandom);    bus.decoded_immediate = 8'($urandom);
        bus.nzp = 12'($urandom);
        @(posedge clk);
        @(negedge clk);
        bus.core_state = ST_IDLE;
    endtask

    task automatic instr(input logic pm, jmp, ssy, snc, input logic [2:0] dnzp,
                         input logic [7:0] imm, input logic [11:0] lnzp);
        model_step(pm, jmp, ssy, snc, dnzp, imm, lnzp);
        drive_execute(pm, jmp, ssy, snc, dnzp, imm, lnzp);
        drive_update();
    endtask

    task automatic do_reset();
        bus.core_state = ST_IDLE;
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.core_state = ST_IDLE;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        tests_run++; if (bus.current_pc !== 8'h00) begin tests_failed++; $display("FAIL reset_pc: got %h want 00", bus.current_pc); end
        tests_run++; if (bus.next_pc !== 8'h00) begin tests_failed++; $display("FAIL reset_next_pc: got %h want 00", bus.next_pc); end
        tests_run++; if (bus.thread_mask !== 4'hF) begin tests_failed++; $display("FAIL reset_mask: got %b want 1111", bus.thread_mask); end
        tests_run++; if (bus.stack_depth !== 2'd0) begin tests_failed++; $display("FAIL reset_depth: got %0d want 0", bus.stack_depth); end
        tests_run++; if ({bus.fault_overflow, bus.fault_underflow, bus.fault_divergence} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_faults: got %b want 000", {bus.fault_overflow, bus.fault_underflow, bus.fault_divergence}); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++; if (bus.current_pc !== 8'h00) begin tests_failed++; $display("FAIL idle_hold_pc: got %h want 00", bus.current_pc); end
    endtask

    task automatic test_default();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            instr(1'b0, 1'b0, 1'b0, 1'b0, 3'($urandom), 8'($urandom), 12'($urandom));
            tests_run++; if (bus.current_pc !== 8'(i)) begin tests_failed++; $display("FAIL default_pc%0d: got %h want %h", i, bus.current_pc, 8'(i)); end
        end
        tests_run++; if (bus.thread_mask !== 4'hF) begin tests_failed++; $display("FAIL default_mask: got %b want 1111", bus.thread_mask); end
        tests_run++; if ({bus.fault_overflow, bus.fault_underflow, bus.fault_divergence} !== 3'b000) begin
            tests_failed++; $display("FAIL default_faults: got %b want 000", {bus.fault_overflow, bus.fault_underflow, bus.fault_divergence}); end
    endtask

    task automatic test_uniform_branch();
        do_reset();
        repeat (5) instr(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 12'h000);
        instr(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 8'h20, {4{3'b010}});
        tests_run++; if (bus.current_pc !== 8'h20) begin tests_failed++; $display("FAIL uniform_pc: got %h want 20", bus.current_pc); end
        tests_run++; if (bus.thread_mask !== 4'hF) begin tests_failed++; $display("FAIL uniform_mask: got %b want 1111", bus.thread_mask); end
        tests_run++; if (bus.stack_depth !== 2'd0) begin tests_failed++; $display("FAIL uniform_depth: got %0d want 0", bus.stack_depth); end
        instr(1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 8'h40, {4{3'b011}});
        tests_run++; if (bus.current_pc !== 8'h21) begin tests_failed++; $display("FAIL none_taken_pc: got %h want 21", bus.current_pc); end
    endtask

    task automatic test_divergent();
        do_reset();
        repeat (2) instr(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 12'h000);
        instr(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 8'h30, 12'h000);
        tests_run++; if (bus.stack_depth !== 2'd1) begin tests_failed++; $display("FAIL div_ssy_depth: got %0d want 1", bus.stack_depth); end
        model_step(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 8'h10, DIV_NZP);
        drive_execute(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 8'h10, DIV_NZP);
        tests_run++; if ({bus.next_pc, bus.current_pc, bus.thread_mask} !== {8'h10, 8'h03, 4'hF}) begin
            tests_failed++; $display("FAIL div_pre_update: got npc=%h pc=%h mask=%b want npc=10 pc=03 mask=1111", bus.next_pc, bus.current_pc, bus.thread_mask); end
        drive_update();
        tests_run++; if ({bus.current_pc, bus.thread_mask} !== {8'h10, 4'b0101}) begin
            tests_failed++; $display("FAIL div_br: got pc=%h mask=%b want pc=10 mask=0101", bus.current_pc, bus.thread_mask); end
        instr(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 8'h00, 12'h000);
        tests_run++; if ({bus.current_pc, bus.thread_mask, bus.stack_depth} !== {8'h04, 4'b1010, 2'd1}) begin
            tests_failed++; $display("FAIL div_sync1: got pc=%h mask=%b depth=%0d want pc=04 mask=1010 depth=1", bus.current_pc, bus.thread_mask, bus.stack_depth); end
        instr(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 8'h00, 12'h000);
        tests_run++; if ({bus.current_pc, bus.thread_mask, bus.stack_depth} !== {8'h31, 4'b1111, 2'd0}) begin
            tests_failed++; $display("FAIL div_sync2: got pc=%h mask=%b depth=%0d want pc=31 mask=1111 depth=0", bus.current_pc, bus.thread_mask, bus.stack_depth); end
    endtask

    task automatic test_overflow();
        do_reset();
        instr(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 8'h40, 12'h000);
        instr(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 8'h50, 12'h000);
        tests_run++; if ({bus.stack_depth, bus.fault_overflow} !== {2'd2, 1'b0}) begin
            tests_failed++; $display("FAIL ovf_full: got depth=%0d ovf=%b want depth=2 ovf=0", bus.stack_depth, bus.fault_overflow); end
        instr(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 8'h60, 12'h000);
        tests_run++; if ({bus.stack_depth, bus.fault_overflow, bus.current_pc} !== {2'd2, 1'b1, 8'h03}) begin
            tests_failed++; $display("FAIL ovf_third: got depth=%0d ovf=%b pc=%h want depth=2 ovf=1 pc=03", bus.stack_depth, bus.fault_overflow, bus.current_pc); end
    endtask

    task automatic test_underflow_divergence();
        do_reset();
        instr(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 8'h00, 12'h000);
        tests_run++; if ({bus.fault_underflow, bus.thread_mask, bus.current_pc} !== {1'b1, 4'hF, 8'h01}) begin
            tests_failed++; $display("FAIL underflow: got unf=%b mask=%b pc=%h want unf=1 mask=1111 pc=01", bus.fault_underflow, bus.thread_mask, bus.current_pc); end
        instr(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 8'h10, DIV_NZP);
        tests_run++; if ({bus.fault_divergence, bus.thread_mask, bus.current_pc, bus.stack_depth} !== {1'b1, 4'hF, 8'h02, 2'd0}) begin
            tests_failed++; $display("FAIL divergence_fault: got div=%b mask=%b pc=%h depth=%0d want div=1 mask=1111 pc=02 depth=0",
                bus.fault_divergence, bus.thread_mask, bus.current_pc, bus.stack_depth); end
    endtask

    task automatic test_wrap();
        do_reset();
        instr(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 8'hFF, 12'h000);
        tests_run++; if (bus.current_pc !== 8'hFF) begin tests_failed++; $display("FAIL jmp_pc: got %h want ff", bus.current_pc); end
        instr(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 12'h000);
        tests_run++; if (bus.current_pc !== 8'h00) begin tests_failed++; $display("FAIL wrap_pc: got %h want 00", bus.current_pc); end
    endtask

    task automatic test_reset_mid_update();
        do_reset();
        instr(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 8'h70, 12'h000);
        instr(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 8'h10, DIV_NZP);
        drive_execute(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 8'h80, 12'h000);
        bus.core_state = ST_UPD;
        #2 reset = 1'b0;
        #1;
        tests_run++; if ({bus.current_pc, bus.stack_depth, bus.thread_mask} !== {8'h00, 2'd0, 4'hF}) begin
            tests_failed++; $display("FAIL async_reset: got pc=%h depth=%0d mask=%b want pc=00 depth=0 mask=1111", bus.current_pc, bus.stack_depth, bus.thread_mask); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus.core_state = ST_IDLE;
        model_reset();
        tests_run++; if ({bus.current_pc, bus.stack_depth, bus.thread_mask} !== {8'h00, 2'd0, 4'hF}) begin
            tests_failed++; $display("FAIL reset_discard: got pc=%h depth=%0d mask=%b want pc=00 depth=0 mask=1111", bus.current_pc, bus.stack_depth, bus.thread_mask); end
        instr(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 12'h000);
        tests_run++; if (bus.current_pc !== 8'h01) begin tests_failed++; $display("FAIL resume_pc: got %h want 01", bus.current_pc); end
    endtask

    task automatic test_random();
        logic pm, jmp, ssy, snc;
        logic [2:0] dnzp;
        logic [7:0] imm, old_pc;
        logic [3:0] old_mask;
        logic [11:0] lnzp;
        int r;
        for (int n = 0; n < 400; n++) begin
            if (n % 25 == 0) do_reset();
            r = $urandom_range(0, 9);
            pm = (r == 3 || r == 4); jmp = (r == 5); ssy = (r == 6 || r == 7); snc = (r >= 8);
            if ($urandom_range(0, 15) == 0) {pm, jmp, ssy, snc} = 4'($urandom);
            dnzp = 3'($urandom); imm = 8'($urandom); lnzp = 12'($urandom);
            old_pc = m_pc; old_mask = m_mask;
            model_step(pm, jmp, ssy, snc, dnzp, imm, lnzp);
            drive_execute(pm, jmp, ssy, snc, dnzp, imm, lnzp);
            tests_run++; if ({bus.next_pc, bus.current_pc, bus.thread_mask} !== {m_npc, old_pc, old_mask}) begin
                tests_failed++; $display("FAIL rand_exec[%0d]: got npc=%h pc=%h mask=%b want npc=%h pc=%h mask=%b",
                    n, bus.next_pc, bus.current_pc, bus.thread_mask, m_npc, old_pc, old_mask); end
            drive_update();
            tests_run++; if ({bus.current_pc, bus.thread_mask, bus.stack_depth, bus.fault_overflow, bus.fault_underflow, bus.fault_divergence}
                    !== {m_pc, m_mask, 2'(stk.size()), m_fo, m_fu, m_fd}) begin
                tests_failed++; $display("FAIL rand_update[%0d]: got pc=%h mask=%b depth=%0d f=%b%b%b want pc=%h mask=%b depth=%0d f=%b%b%b",
                    n, bus.current_pc, bus.thread_mask, bus.stack_depth, bus.fault_overflow, bus.fault_underflow, bus.fault_divergence,
                    m_pc, m_mask, stk.size(), m_fo, m_fu, m_fd); end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        bus.core_state = ST_IDLE;
        bus.decoded_pc_mux = 1'b0; bus.decoded_jump = 1'b0;
        bus.decoded_ssy = 1'b0;    bus.decoded_sync = 1'b0;
        bus.decoded_nzp = 3'b000;  bus.decoded_immediate = 8'h00;
        bus.nzp = 12'h000;
        test_reset();
        test_default();
        test_uniform_branch();
        test_divergent();
        test_overflow();
        test_underflow_divergence();
        test_wrap();
        test_reset_mid_update();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
